// File: rtl/pong_pkg.sv
// Shared constants, command codes and FSM encoding for the pong ball controller.
// The optional paddle-speedup feature is enabled by defining BALL_SPEEDUP_EN.
package pong_pkg;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int BALL_R         = 4;
  localparam int LEFT_PADDLE_X  = 16;
  localparam int RIGHT_PADDLE_X = 624;
  localparam int PADDLE_HALF_W  = 2;
  localparam int PADDLE_HALF_H  = 24;
  localparam int SERVE_FRAMES   = 60;

  localparam logic [9:0] BALL_RESET_X = 10'd320;
  localparam logic [9:0] BALL_RESET_Y = 10'd220;

  localparam logic [3:0] CW_HOLD       = 4'b0000;
  localparam logic [3:0] CW_DOWN_RIGHT = 4'b0001;
  localparam logic [3:0] CW_UP_LEFT    = 4'b0010;
  localparam logic [3:0] CW_DOWN_LEFT  = 4'b0011;
  localparam logic [3:0] CW_UP_RIGHT   = 4'b0100;
  localparam logic [3:0] CW_RESET      = 4'b0101;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    MOVE  = 2'd1,
    EMIT  = 2'd2
  } state_t;

  function automatic logic [3:0] dir_code(input logic dx_right, input logic dy_down);
    case ({dx_right, dy_down})
      2'b11:   dir_code = CW_DOWN_RIGHT;
      2'b00:   dir_code = CW_UP_LEFT;
      2'b01:   dir_code = CW_DOWN_LEFT;
      default: dir_code = CW_UP_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/ball_hit_detect.sv
// Combinational collision classifier: misses, paddle hits and wall bounces
// for the current ball centre, paddle positions and travel direction.
module ball_hit_detect
  import pong_pkg::*;
(
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] left_py,
  input  logic [9:0] right_py,
  input  logic       dx_right,
  input  logic       dy_down,
  output logic       miss_l,
  output logic       miss_r,
  output logic       hit_l,
  output logic       hit_r,
  output logic       wall_t,
  output logic       wall_b
);

  localparam logic [9:0]  R10       = 10'(BALL_R);
  localparam logic [9:0]  MISS_R_X  = 10'(SCREEN_W - 1 - BALL_R);
  localparam logic [9:0]  L_FACE_X  = 10'(LEFT_PADDLE_X + PADDLE_HALF_W);
  localparam logic [9:0]  R_FACE_X  = 10'(RIGHT_PADDLE_X - PADDLE_HALF_W);
  localparam logic [9:0]  BOTTOM_Y  = 10'(SCREEN_H - 1 - BALL_R);
  localparam logic [10:0] REACH     = 11'(PADDLE_HALF_H + BALL_R);

  // Vertical offsets are taken in 11-bit signed so a paddle near y=0 never wraps.
  logic signed [10:0] off_l, off_r;
  logic [10:0]        abs_l, abs_r;

  assign off_l = $signed({1'b0, ball_y}) - $signed({1'b0, left_py});
  assign off_r = $signed({1'b0, ball_y}) - $signed({1'b0, right_py});
  assign abs_l = off_l[10] ? 11'(-off_l) : 11'(off_l);
  assign abs_r = off_r[10] ? 11'(-off_r) : 11'(off_r);

  assign miss_l = ball_x <= R10;
  assign miss_r = ball_x >= MISS_R_X;
  assign hit_l  = !dx_right && ((ball_x - R10) <= L_FACE_X) && (abs_l <= REACH);
  assign hit_r  = dx_right && ((ball_x + R10) >= R_FACE_X) && (abs_r <= REACH);
  assign wall_t = !dy_down && (ball_y <= R10);
  assign wall_b = dy_down && (ball_y >= BOTTOM_Y);

endmodule

// File: rtl/ball_control_fsm.sv
// Per-frame ball controller: serve timing, bounce resolution and movement command words.
// Define BALL_SPEEDUP_EN to lengthen each move as paddle hits accumulate.
module ball_control_fsm
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       move_tick,
  input  logic       serve_btn,
  input  logic [9:0] ball_center_x,
  input  logic [9:0] ball_center_y,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic [3:0] cw_ballMovement,
  output logic       score_left,
  output logic       score_right
);

  state_t      state_q, state_d;
  logic        dx_q, dx_d;
  logic        dy_q, dy_d;
  logic [5:0]  serve_cnt_q, serve_cnt_d;
  logic [2:0]  step_cnt_q, step_cnt_d;
  logic [2:0]  steps_q, steps_d;
  logic [3:0]  cw_q, cw_d;
  logic        score_l_q, score_l_d;
  logic        score_r_q, score_r_d;
  logic        nx, ny;

`ifdef BALL_SPEEDUP_EN
  logic [3:0]  hits_q, hits_d, hits_nx;
`endif

  logic miss_l, miss_r, hit_l, hit_r, wall_t, wall_b;

  ball_hit_detect u_hit (
    .ball_x   (ball_center_x),
    .ball_y   (ball_center_y),
    .left_py  (left_paddle_y),
    .right_py (right_paddle_y),
    .dx_right (dx_q),
    .dy_down  (dy_q),
    .miss_l   (miss_l),
    .miss_r   (miss_r),
    .hit_l    (hit_l),
    .hit_r    (hit_r),
    .wall_t   (wall_t),
    .wall_b   (wall_b)
  );

  always_comb begin
    state_d     = state_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_cnt_d = serve_cnt_q;
    step_cnt_d  = step_cnt_q;
    steps_d     = steps_q;
    cw_d        = CW_HOLD;
    score_l_d   = 1'b0;
    score_r_d   = 1'b0;
    nx          = dx_q;
    ny          = dy_q;
`ifdef BALL_SPEEDUP_EN
    hits_d      = hits_q;
    hits_nx     = hits_q;
`endif
    case (state_q)
      SERVE: begin
        if (serve_btn || (move_tick && serve_cnt_q == 6'(SERVE_FRAMES - 1))) begin
          state_d     = MOVE;
          serve_cnt_d = '0;
        end else if (move_tick) begin
          serve_cnt_d = serve_cnt_q + 6'd1;
        end
      end
      MOVE: begin
        if (move_tick) begin
          if (miss_l || miss_r) begin
            score_r_d   = miss_l;
            score_l_d   = !miss_l;
            dx_d        = miss_l;
            cw_d        = CW_RESET;
            serve_cnt_d = '0;
            state_d     = SERVE;
`ifdef BALL_SPEEDUP_EN
            hits_d      = '0;
`endif
          end else begin
            if (hit_l)      nx = 1'b1;
            else if (hit_r) nx = 1'b0;
            if (wall_t)      ny = 1'b1;
            else if (wall_b) ny = 1'b0;
`ifdef BALL_SPEEDUP_EN
            if ((hit_l || hit_r) && hits_q != 4'hf) hits_nx = hits_q + 4'd1;
            hits_d  = hits_nx;
            steps_d = 3'd1 + {1'b0, hits_nx[3:2]};
`endif
            dx_d       = nx;
            dy_d       = ny;
            cw_d       = dir_code(nx, ny);
            step_cnt_d = 3'd1;
            state_d    = EMIT;
          end
        end
      end
      EMIT: begin
        // The command went out on the MOVE->EMIT edge; extend it until steps cycles elapse.
        if (step_cnt_q >= steps_q) begin
          step_cnt_d = '0;
          state_d    = MOVE;
        end else begin
          cw_d       = dir_code(dx_q, dy_q);
          step_cnt_d = step_cnt_q + 3'd1;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= SERVE;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      serve_cnt_q <= '0;
      step_cnt_q  <= '0;
      steps_q     <= 3'd1;
      cw_q        <= CW_HOLD;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      hits_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_cnt_q <= serve_cnt_d;
      step_cnt_q  <= step_cnt_d;
      steps_q     <= steps_d;
      cw_q        <= cw_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
`ifdef BALL_SPEEDUP_EN
      hits_q      <= hits_d;
`endif
    end
  end

  assign cw_ballMovement = cw_q;
  assign score_left      = score_l_q;
  assign score_right     = score_r_q;

endmodule
